// File: rtl/sba_initiator.sv
// System bus access initiator: exposes sbcs / sbaddress0 / sbdata0 to the
// debug module and drives single-beat, word-aligned bus reads and writes.
module sba_initiator #(
  parameter int TimeoutCycles = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  dm_addr,
  input  logic        dm_we,
  input  logic        dm_re,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic [31:0] bus_address,
  output logic [31:0] bus_data_out,
  output logic [3:0]  bus_byte_enable,
  output logic        bus_read,
  output logic        bus_write,
  input  logic [31:0] bus_data_in,
  input  logic        bus_ack
);

  localparam int CW = $clog2(TimeoutCycles + 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] sbaddress0, sbdata0;
  logic [2:0]  sbaccess, sberror;
  logic        sbreadonaddr, sbreadondata, sbautoincrement, sbbusyerror;
  logic        sbbusy, in_req;
  logic [CW-1:0] cnt;
  // Access size and low address bits of the transfer in flight; sbcs may be
  // rewritten mid-transfer without affecting the return path.
  logic [1:0]  req_acc, req_lo;

  logic        wr_sbcs, wr_addr, wr_data, rd_data;
  logic        no_err, trig_rd, trig_wr, trig, acc_bad, misalign, go;
  logic        busy_hit, ack_ok, tmo;
  logic [31:0] trig_addr, rd_shift, rd_val;

  assign wr_sbcs = dm_we && (dm_addr == 2'd0);
  assign wr_addr = dm_we && (dm_addr == 2'd1);
  assign wr_data = dm_we && (dm_addr == 2'd2);
  assign rd_data = dm_re && (dm_addr == 2'd2) && sbreadondata;

  assign no_err    = (sberror == 3'd0) && !sbbusyerror;
  assign trig_rd   = !sbbusy && no_err && ((wr_addr && sbreadonaddr) || rd_data);
  assign trig_wr   = !sbbusy && no_err && wr_data;
  assign trig      = trig_rd || trig_wr;
  // A sbaddress0 write that triggers a read uses the address being written.
  assign trig_addr = wr_addr ? dm_wdata : sbaddress0;
  assign acc_bad   = sbaccess > 3'd2;
  assign misalign  = ((sbaccess == 3'd1) && trig_addr[0]) ||
                     ((sbaccess == 3'd2) && (trig_addr[1:0] != 2'd0));
  assign go        = trig && !acc_bad && !misalign;
  assign busy_hit  = sbbusy && (wr_addr || wr_data || rd_data);
  assign ack_ok    = in_req && bus_ack;
  // Ack in the final allowed cycle wins over the timeout.
  assign tmo       = in_req && !bus_ack && (cnt == CW'(TimeoutCycles - 1));

  // Read return: align the addressed lane to bit 0, zero-extend to size.
  assign rd_shift = bus_data_in >> {req_lo, 3'b000};
  always_comb begin
    rd_val = rd_shift;
    case (req_acc)
      2'd0:    rd_val = {24'd0, rd_shift[7:0]};
      2'd1:    rd_val = {16'd0, rd_shift[15:0]};
      default: rd_val = rd_shift;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go) state_d = REQ;
      REQ:     if (bus_ack) state_d = DONE;
               else if (tmo) state_d = IDLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State decode.
  always_comb begin
    sbbusy = (state_q != IDLE);
    in_req = (state_q == REQ);
  end

  // Bus request registers: loaded on a legal trigger, held through REQ.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_read        <= 1'b0;
      bus_write       <= 1'b0;
      bus_address     <= 32'd0;
      bus_data_out    <= 32'd0;
      bus_byte_enable <= 4'd0;
      req_acc         <= 2'd0;
      req_lo          <= 2'd0;
      cnt             <= '0;
    end else if (go) begin
      bus_read    <= trig_rd;
      bus_write   <= trig_wr;
      bus_address <= {trig_addr[31:2], 2'b00};
      req_acc     <= sbaccess[1:0];
      req_lo      <= trig_addr[1:0];
      cnt         <= '0;
      case (sbaccess[1:0])
        2'd0: begin
          bus_byte_enable <= 4'b0001 << trig_addr[1:0];
          bus_data_out    <= {4{dm_wdata[7:0]}};
        end
        2'd1: begin
          bus_byte_enable <= 4'b0011 << trig_addr[1:0];
          bus_data_out    <= {2{dm_wdata[15:0]}};
        end
        default: begin
          bus_byte_enable <= 4'b1111;
          bus_data_out    <= dm_wdata;
        end
      endcase
    end else if (ack_ok || tmo) begin
      bus_read  <= 1'b0;
      bus_write <= 1'b0;
    end else if (in_req) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Debug-visible registers: sbcs fields, sbaddress0, sbdata0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sbaddress0      <= 32'd0;
      sbdata0         <= 32'd0;
      sbaccess        <= 3'd2;
      sbreadonaddr    <= 1'b0;
      sbreadondata    <= 1'b0;
      sbautoincrement <= 1'b0;
      sberror         <= 3'd0;
      sbbusyerror     <= 1'b0;
    end else begin
      if (wr_sbcs) begin
        sbreadonaddr    <= dm_wdata[20];
        sbaccess        <= dm_wdata[19:17];
        sbautoincrement <= dm_wdata[16];
        sbreadondata    <= dm_wdata[15];
      end
      // W1C first, then a new error overrides so it is never lost.
      if (trig && acc_bad)       sberror <= 3'd4;
      else if (trig && misalign) sberror <= 3'd3;
      else if (tmo)              sberror <= 3'd1;
      else if (wr_sbcs)          sberror <= sberror & ~dm_wdata[14:12];
      if (busy_hit)              sbbusyerror <= 1'b1;
      else if (wr_sbcs && dm_wdata[22]) sbbusyerror <= 1'b0;

      if (ack_ok && sbautoincrement)
        sbaddress0 <= sbaddress0 + (32'd1 << req_acc);
      else if (wr_addr && !sbbusy)
        sbaddress0 <= dm_wdata;

      if (ack_ok && bus_read)
        sbdata0 <= rd_val;
      else if (wr_data && !sbbusy)
        sbdata0 <= dm_wdata;
    end
  end

  // Combinational register read mux.
  always_comb begin
    dm_rdata = 32'd0;
    case (dm_addr)
      2'd0: dm_rdata = {3'd1, 6'd0, sbbusyerror, sbbusy, sbreadonaddr, sbaccess,
                        sbautoincrement, sbreadondata, sberror, 7'd32, 2'd0, 3'b111};
      2'd1: dm_rdata = sbaddress0;
      2'd2: dm_rdata = sbdata0;
      default: dm_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_sba_initiator.sv
// Directed bench for sba_initiator: register table plus bus-transfer sequences.
module tb_sba_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  dm_addr;
  logic        dm_we, dm_re;
  logic [31:0] dm_wdata, dm_rdata;
  logic [31:0] bus_address, bus_data_out, bus_data_in;
  logic [3:0]  bus_byte_enable;
  logic        bus_read, bus_write, bus_ack;

  int checks = 0;
  int errors = 0;

  sba_initiator #(.TimeoutCycles(64)) dut (
    .clk(clk), .rst_n(rst_n), .dm_addr(dm_addr), .dm_we(dm_we), .dm_re(dm_re),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .bus_address(bus_address),
    .bus_data_out(bus_data_out), .bus_byte_enable(bus_byte_enable),
    .bus_read(bus_read), .bus_write(bus_write), .bus_data_in(bus_data_in),
    .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [1:0] a, output logic [31:0] d);
    dm_addr = a;
    #1;
    d = dm_rdata;
  endtask

  task automatic peek_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    peek(a, d);
    chk(name, d, exp);
  endtask

  task automatic dm_write(input logic [1:0] a, input logic [31:0] d);
    dm_addr = a; dm_wdata = d; dm_we = 1'b1;
    tick();
    dm_we = 1'b0;
  endtask

  task automatic ack_with(input logic [31:0] d);
    bus_ack = 1'b1; bus_data_in = d;
    tick();
    bus_ack = 1'b0; bus_data_in = 32'd0;
  endtask

  initial begin
    int n;
    vecs[0]  = '{1'b0, 2'd0, 32'h0,        2'd0, 32'h2004_0407};
    vecs[1]  = '{1'b0, 2'd0, 32'h0,        2'd1, 32'h0};
    vecs[2]  = '{1'b0, 2'd0, 32'h0,        2'd2, 32'h0};
    vecs[3]  = '{1'b1, 2'd3, 32'hFFFF_FFFF, 2'd3, 32'h0};
    vecs[4]  = '{1'b1, 2'd0, 32'hFFFF_FFFF, 2'd0, 32'h201F_8407};
    vecs[5]  = '{1'b1, 2'd0, 32'h0004_0000, 2'd0, 32'h2004_0407};
    vecs[6]  = '{1'b1, 2'd1, 32'h1234_5678, 2'd1, 32'h1234_5678};
    vecs[7]  = '{1'b1, 2'd0, 32'h0006_0000, 2'd0, 32'h2006_0407};
    vecs[8]  = '{1'b1, 2'd2, 32'h0000_0055, 2'd0, 32'h2006_4407};
    vecs[9]  = '{1'b1, 2'd0, 32'h0004_7000, 2'd0, 32'h2004_0407};
    vecs[10] = '{1'b0, 2'd0, 32'h0,        2'd2, 32'h0000_0055};
    vecs[11] = '{1'b0, 2'd0, 32'h0,        2'd1, 32'h1234_5678};

    rst_n = 1'b0; dm_addr = 2'd0; dm_we = 1'b0; dm_re = 1'b0; dm_wdata = 32'd0;
    bus_ack = 1'b0; bus_data_in = 32'd0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_strobes", {30'd0, bus_read, bus_write}, 32'd0);
    chk("rst_be", {28'd0, bus_byte_enable}, 32'd0);

    // Register table
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].we) dm_write(vecs[i].addr, vecs[i].wdata);
      peek_chk($sformatf("tbl%0d", i), vecs[i].raddr, vecs[i].exp);
      chk($sformatf("tbl%0d_strobe", i), {30'd0, bus_read, bus_write}, 32'd0);
    end

    // Word read on address write, ack after 2 cycles
    dm_write(2'd0, 32'h0014_0000);
    dm_write(2'd1, 32'h0000_1000);
    chk("A_read", {31'd0, bus_read}, 32'd1);
    chk("A_addr", bus_address, 32'h1000);
    chk("A_be", {28'd0, bus_byte_enable}, 32'hF);
    tick();
    chk("A_hold", {31'd0, bus_read}, 32'd1);
    ack_with(32'hDEAD_BEEF);
    chk("A_drop", {31'd0, bus_read}, 32'd0);
    peek_chk("A_done_busy", 2'd0, 32'h2034_0407);
    peek_chk("A_data", 2'd2, 32'hDEAD_BEEF);
    tick();
    peek_chk("A_idle", 2'd0, 32'h2014_0407);

    // Byte write with autoincrement, immediate ack (3-cycle latency)
    dm_write(2'd0, 32'h0001_0000);
    dm_write(2'd1, 32'h0000_2003);
    dm_write(2'd2, 32'h0000_00A5);
    chk("B_write", {31'd0, bus_write}, 32'd1);
    chk("B_be", {28'd0, bus_byte_enable}, 32'h8);
    chk("B_data", bus_data_out, 32'hA5A5_A5A5);
    chk("B_addr", bus_address, 32'h2000);
    ack_with(32'd0);
    peek_chk("B_done_busy", 2'd0, 32'h2021_0407);
    tick();
    peek_chk("B_idle", 2'd0, 32'h2001_0407);
    peek_chk("B_inc", 2'd1, 32'h2004);

    // Halfword read on sbdata0 read, upper half lane
    dm_write(2'd0, 32'h0002_8000);
    dm_write(2'd1, 32'h0000_4002);
    dm_addr = 2'd2; dm_re = 1'b1;
    #1;
    chk("H_old_data", dm_rdata, 32'hA5);
    tick();
    dm_re = 1'b0;
    chk("H_read", {31'd0, bus_read}, 32'd1);
    chk("H_be", {28'd0, bus_byte_enable}, 32'hC);
    chk("H_addr", bus_address, 32'h4000);
    ack_with(32'h1234_5678);
    peek_chk("H_data", 2'd2, 32'h0000_1234);
    tick();

    // Misaligned halfword write
    dm_write(2'd0, 32'h0002_0000);
    dm_write(2'd1, 32'h0000_3001);
    dm_write(2'd2, 32'h0000_BEEF);
    chk("C_nostrobe", {30'd0, bus_read, bus_write}, 32'd0);
    peek_chk("C_err3", 2'd0, 32'h2002_3407);
    dm_write(2'd0, 32'h0002_7000);
    peek_chk("C_w1c", 2'd0, 32'h2002_0407);

    // Read with no ack: timeout
    dm_write(2'd0, 32'h0014_0000);
    dm_write(2'd1, 32'h0000_5000);
    n = 0;
    for (int k = 0; k < 100 && bus_read; k++) begin
      n++;
      tick();
    end
    chk("D_req_cycles", n, 32'd64);
    peek_chk("D_err1", 2'd0, 32'h2014_1407);
    peek_chk("D_data_kept", 2'd2, 32'h0000_BEEF);
    peek_chk("D_addr_kept", 2'd1, 32'h5000);
    dm_write(2'd0, 32'h0014_7000);

    // Ack in the last allowed cycle is a success
    dm_write(2'd1, 32'h0000_5004);
    repeat (63) tick();
    chk("T_still_req", {31'd0, bus_read}, 32'd1);
    ack_with(32'h0F0F_0F0F);
    peek_chk("T_ok", 2'd0, 32'h2034_0407);
    peek_chk("T_data", 2'd2, 32'h0F0F_0F0F);
    tick();

    // Busy error on sbdata0 write mid-transfer
    dm_write(2'd0, 32'h0004_0000);
    dm_write(2'd1, 32'h0000_6000);
    dm_write(2'd2, 32'h1111_1111);
    dm_write(2'd2, 32'h2222_2222);
    chk("E_write", {31'd0, bus_write}, 32'd1);
    chk("E_data", bus_data_out, 32'h1111_1111);
    chk("E_addr", bus_address, 32'h6000);
    peek_chk("E_busyerr", 2'd0, 32'h2064_0407);
    ack_with(32'd0);
    tick();
    peek_chk("E_sbdata", 2'd2, 32'h1111_1111);
    dm_write(2'd2, 32'h0000_0033);
    chk("E_blocked", {31'd0, bus_write}, 32'd0);
    dm_write(2'd0, 32'h0044_0000);
    peek_chk("E_w1c", 2'd0, 32'h2004_0407);
    dm_write(2'd2, 32'h0000_0044);
    chk("E_resume", {31'd0, bus_write}, 32'd1);
    chk("E_resume_data", bus_data_out, 32'h44);

    // Reset during REQ, then a late ack
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("R_strobes", {30'd0, bus_read, bus_write}, 32'd0);
    chk("R_addr", bus_address, 32'd0);
    chk("R_dout", bus_data_out, 32'd0);
    chk("R_be", {28'd0, bus_byte_enable}, 32'd0);
    peek_chk("R_sbcs", 2'd0, 32'h2004_0407);
    peek_chk("R_sbaddr", 2'd1, 32'd0);
    ack_with(32'hFFFF_FFFF);
    peek_chk("R_late_ack", 2'd2, 32'd0);
    peek_chk("R_idle", 2'd0, 32'h2004_0407);
    chk("R_nostrobe", {30'd0, bus_read, bus_write}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
